sram_ctrl: RTL and testbench

- Initiator-side controller for the single-port synchronous SRAM macro (clk, nWE, adr, d_in, registered d_out).
- Converts a valid/ready host request stream into correctly timed SRAM cycles: single-beat writes, and incrementing read bursts with wrap-around.
- Returns read data on a valid/ready response channel with backpressure; sits between bus/CPU logic and the SRAM instance.

---
 rtl/sram_ctrl.sv | 118 +++++++++++
 tb/tb_sram_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// ============================================================================
// sram_ctrl : valid/ready host front-end for a single-port synchronous SRAM
// Rev 1.0   : single-beat writes, wrapping incrementing read bursts
// ============================================================================
`default_nettype none

module sram_ctrl #(
  parameter int AW = 2,
  parameter int DW = 2,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_wdata,
  input  logic [LW-1:0] req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic          wr_done,
  output logic          busy,
  output logic          mem_nWE,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD_ADR = 3'd2,
    RD_CAP = 3'd3,
    RSP    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          wr_done_q, wr_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    wr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          adr_d   = req_adr;
          din_d   = req_wdata;
          cnt_d   = req_len;
          state_d = req_we ? WR : RD_ADR;
        end
      end
      WR: begin
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end
      RD_ADR: state_d = RD_CAP;
      // SRAM output is registered, so data for adr_q is only visible now
      RD_CAP: begin
        rdata_d = mem_dout;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - LW'(1);
            adr_d   = adr_q + AW'(1);
            state_d = RD_ADR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_nWE   = (state_q != WR);
  assign mem_adr   = adr_q;
  assign mem_din   = din_q;
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_last  = (state_q == RSP) && (cnt_q == '0);
  assign wr_done   = wr_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl.sv
// ============================================================================
// tb_sram_ctrl : table-driven, directed and randomized checks of sram_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_adr;
  logic [1:0] req_wdata;
  logic [1:0] req_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_rdata;
  logic       rsp_last;
  logic       wr_done;
  logic       busy;
  logic       mem_nWE;
  logic [1:0] mem_adr;
  logic [1:0] mem_din;
  logic [1:0] mem_dout;

  sram_ctrl #(.AW(2), .DW(2), .LW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .wr_done   (wr_done),
    .busy      (busy),
    .mem_nWE   (mem_nWE),
    .mem_adr   (mem_adr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // SRAM macro: write on nWE=0, registered read data
  logic [1:0] sram [4];
  always @(posedge clk) begin
    if (!mem_nWE) sram[mem_adr] <= mem_din;
    mem_dout <= sram[mem_adr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [1:0] wdata;
    logic [1:0] len;
    logic [7:0] exp;   // beat i expected data at [2i+:2]
  } vec_t;

  typedef struct {
    logic [1:0] d;
    logic       l;
  } beat_t;

  vec_t       tbl [11];
  beat_t      exp_q [$];
  logic [1:0] ref_mem [4];
  int         wr_exp = 0;
  int         wr_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [1:0] adr, input logic [1:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_adr = adr; req_wdata = data;
    check("wr_accept_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("wr_nwe_low", mem_nWE, 0);
    check("wr_adr", mem_adr, adr);
    check("wr_din", mem_din, data);
    check("wr_busy", busy, 1);
    check("wr_ready_low", req_ready, 0);
    tick();
    check("wr_nwe_back", mem_nWE, 1);
    check("wr_done_pulse", wr_done, 1);
    check("wr_ready_back", req_ready, 1);
    tick();
    check("wr_done_clear", wr_done, 0);
  endtask

  task automatic do_read(input logic [1:0] adr, input logic [1:0] len,
                         input logic [7:0] exp, input string nm);
    int         n;
    logic [1:0] a;
    logic [7:0] e;
    req_valid = 1'b1; req_we = 1'b0; req_adr = adr; req_len = len; rsp_ready = 1'b1;
    check({nm, "_accept_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    e = exp;
    for (int b = 0; b <= int'(len); b++) begin
      wait_rsp(n);
      a = adr + 2'(b);
      check({nm, "_latency"}, n, 2);
      check({nm, "_data"}, rsp_rdata, e[2*b +: 2]);
      check({nm, "_last"}, rsp_last, (b == int'(len)) ? 1 : 0);
      check({nm, "_mem_adr"}, mem_adr, a);
      tick();
    end
    check({nm, "_end_valid"}, rsp_valid, 0);
    check({nm, "_end_busy"}, busy, 0);
    check({nm, "_end_ready"}, req_ready, 1);
  endtask

  // One cycle with the reference model observing this cycle's handshakes
  task automatic tick_mon();
    beat_t bt;
    if (req_valid && req_ready) begin
      if (req_we) begin
        ref_mem[req_adr] = req_wdata;
        wr_exp++;
      end else begin
        for (int i = 0; i <= int'(req_len); i++) begin
          bt.d = ref_mem[(int'(req_adr) + i) % 4];
          bt.l = (i == int'(req_len));
          exp_q.push_back(bt);
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      check("rnd_beat_expected", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        bt = exp_q.pop_front();
        check("rnd_data", rsp_rdata, bt.d);
        check("rnd_last", rsp_last, bt.l);
      end
    end
    if (wr_done) wr_cnt++;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b0;

    tbl[0]  = '{1'b1, 2'd0, 2'd1, 2'd0, 8'h00};
    tbl[1]  = '{1'b1, 2'd1, 2'd3, 2'd0, 8'h00};
    tbl[2]  = '{1'b0, 2'd1, 2'd0, 2'd0, 8'b00_00_00_11};
    tbl[3]  = '{1'b1, 2'd2, 2'd2, 2'd0, 8'h00};
    tbl[4]  = '{1'b1, 2'd3, 2'd0, 2'd0, 8'h00};
    tbl[5]  = '{1'b0, 2'd3, 2'd0, 2'd2, 8'b00_11_01_00};
    tbl[6]  = '{1'b0, 2'd0, 2'd0, 2'd3, 8'b00_10_11_01};
    tbl[7]  = '{1'b1, 2'd1, 2'd2, 2'd0, 8'h00};
    tbl[8]  = '{1'b0, 2'd1, 2'd0, 2'd0, 8'b00_00_00_10};
    tbl[9]  = '{1'b1, 2'd1, 2'd3, 2'd0, 8'h00};
    tbl[10] = '{1'b0, 2'd2, 2'd0, 2'd1, 8'b00_00_00_10};

    tick(); tick();
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_nwe", mem_nWE, 1);
    check("rst_adr", mem_adr, 0);
    check("rst_din", mem_din, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_last", rsp_last, 0);
    check("rst_wr_done", wr_done, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", req_ready, 1);

    foreach (tbl[i]) begin
      if (tbl[i].we) do_write(tbl[i].adr, tbl[i].wdata);
      else           do_read(tbl[i].adr, tbl[i].len, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Backpressure on the middle beat of a wrapping burst (mem = 1,3,2,0)
    req_valid = 1'b1; req_we = 1'b0; req_adr = 2'd3; req_len = 2'd2; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    check("bp_beat0_data", rsp_rdata, 0);
    tick();
    rsp_ready = 1'b0;
    wait_rsp(n);
    check("bp_beat1_latency", n, 2);
    repeat (5) begin
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_rdata, 1);
      check("bp_hold_adr", mem_adr, 0);
      check("bp_hold_last", rsp_last, 0);
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_release_valid", rsp_valid, 1);
    tick();
    check("bp_no_extra_beat", rsp_valid, 0);
    wait_rsp(n);
    check("bp_beat2_latency", n, 2);
    check("bp_beat2_data", rsp_rdata, 3);
    check("bp_beat2_last", rsp_last, 1);
    tick();
    check("bp_end_busy", busy, 0);

    // Reset while a response is pending mid-burst
    req_valid = 1'b1; req_we = 1'b0; req_adr = 2'd0; req_len = 2'd3; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(n);
    tick();
    rsp_ready = 1'b0;
    wait_rsp(n);
    check("mid_rst_in_rsp", rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_nwe", mem_nWE, 1);
    check("mid_rst_last", rsp_last, 0);
    do_read(2'd2, 2'd0, 8'd2, "post_rst");

    // Randomized traffic against the reference model
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = 2'($urandom_range(0, 3));
      do_write(2'(i), ref_mem[i]);
    end
    for (int t = 0; t < 150; t++) begin
      req_we    = 1'($urandom_range(0, 1));
      req_adr   = 2'($urandom_range(0, 3));
      req_wdata = 2'($urandom_range(0, 3));
      req_len   = 2'($urandom_range(0, 3));
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 60) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        tick_mon();
        n++;
      end
      if (n >= 60) check("rnd_accept_timeout", req_ready, 1);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick_mon();
      req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        tick_mon();
      end
    end
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      tick_mon();
      n++;
    end
    tick_mon();
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_idle", busy, 0);
    check("rnd_wr_done_count", wr_cnt, wr_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
